l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

- Two-requester controller in front of the single-port 64-bit L2 SRAM slice.
- Accepts read requests from the L1 instruction side and read/write requests from the L1 data side.
- Arbitrates round-robin, sequences each access onto the SRAM, and returns a registered response pulse to the winner.
- Range-checks addresses against the slice size and maintains grant/conflict performance counters.

## Interface
Parameters:
- L2_SLICE_SIZE, 262144, slice bytes; power of two; SRAM word index is addr[$clog2(L2_SLICE_SIZE)-1:3]
- CNT_W, 32, width of performance counters

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_req_valid  in  1  instruction read request
- i_req_ready  out  1  instruction request accepted this cycle
- i_req_addr  in  32  instruction byte address; bits [2:0] ignored
- i_rsp_valid  out  1  one-cycle instruction response pulse
- i_rsp_err  out  1  address out of range, valid with i_rsp_valid
- i_rsp_data  out  64  read data, valid with i_rsp_valid
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = write, 0 = read
- d_req_addr  in  32  data byte address; bits [2:0] ignored
- d_req_wdata  in  64  write data
- d_req_wstrb  in  8  byte write strobes
- d_rsp_valid  out  1  one-cycle data response pulse; also the write acknowledge
- d_rsp_err  out  1  address out of range
- d_rsp_data  out  64  read data; 0 for writes
- sram_en  out  1  SRAM ME
- sram_read  out  1  1 = read; drives SRAM WE as inverse
- sram_wstrb  out  8  byte strobes; expanded to the bit mask outside this block
- sram_addr  out  32  byte address to SRAM
- sram_wdata  out  64  SRAM D
- sram_rdata  in  64  SRAM Q; valid the cycle after the enable edge
- perf_i_grants  out  CNT_W  count of instruction grants
- perf_d_grants  out  CNT_W  count of data grants
- perf_conflicts  out  CNT_W  count of cycles where both requesters are valid in IDLE

## Operation
FSM states are IDLE, ACCESS and WAIT.

- **IDLE**
  - Arbitrates among valid requesters; a ready is asserted only in IDLE, and only to the winner.
  - The ready signal is combinational from valid and the round-robin pointer.
  - On handshake: latch requester id, we, addr, wdata, wstrb, and range_err = (addr >= L2_SLICE_SIZE).
  - Then go to ACCESS.
- **Arbitration**
  - Single valid requester: it wins.
  - Both valid: the side not granted last wins.
  - Pointer resets to "I wins next on conflict".
  - The pointer updates on every grant.
- **ACCESS** (always one cycle, then WAIT)
  - sram_en = !range_err.
  - sram_read = !we.
  - sram_wstrb = we ? wstrb : 0.
  - sram_addr and sram_wdata come from the latches.
- **WAIT** (always one cycle, then IDLE)
  - SRAM output is valid in this cycle.
  - At the exiting edge, register the response:
    - the selected rsp_valid goes to 1;
    - err = range_err;
    - data = (read && !range_err) ? sram_rdata : 0.
- **Out-of-range requests**
  - Never enable the SRAM.
  - Keep normal latency.
  - Respond with err=1 and data=0.
- **wstrb = 0 writes**
  - SRAM is enabled with no bytes changed.
  - A normal ack is returned.
- **Counters**
  - Increment by 1 per event.
  - Wrap modulo 2^CNT_W.

## Timing
- **Reset values** (applied at the first edge with rst=1)
  - State = IDLE, pointer = I.
  - All rsp_valid, rsp_err and rsp_data outputs are 0.
  - sram_en = 0, sram_read = 1, sram_wstrb = 0, sram_addr = 0, sram_wdata = 0.
  - All perf counters are 0.
  - Ready outputs are 0 while rst=1.
- **Latency**
  - Handshake at edge E0.
  - ACCESS in cycle E0–E1; SRAM samples at E1.
  - WAIT in cycle E1–E2.
  - rsp_valid is high for exactly the cycle E2–E3 and is then deasserted.
  - Request to response is 3 cycles.
- **Throughput**
  - The FSM is back in IDLE in the same cycle rsp_valid is high, so a new handshake may occur there.
  - Maximum rate is 1 access per 3 cycles.
- **Back-pressure**
  - Responses cannot be back-pressured; requesters must accept the pulse.
  - Requesters hold valid and payload until ready.
- **Simultaneous events**
  - A request presented during ACCESS or WAIT sees ready=0 and is taken in the next IDLE.
- **Reset mid-operation**
  - rst in ACCESS or WAIT returns the FSM to IDLE at that edge.
  - The in-flight access produces no response pulse.
  - sram_en is 0 from the next cycle.

## Test plan
- **Reset**: hold rst 2 cycles with both valids high → all outputs at reset values, both readies 0; the first IDLE cycle after reset grants I.
- **Data write, then read**:
  - d write to addr 0x100, wdata 0x1122334455667788, wstrb 0xFF → d_rsp_valid 3 cycles after handshake, err=0, data=0.
  - Then d read of 0x104 → data 0x1122334455667788.
- **Partial strobe**: write 0xFFFFFFFFFFFFFFFF to 0x100 with wstrb 0x0F, then read → 0x11223344FFFFFFFF.
- **Conflict**: i and d both valid continuously for 4 grants → grant order I, D, I, D; perf_conflicts = 4 (one per IDLE cycle with both valid); perf_i_grants = perf_d_grants = 2.
- **Out of range**: d read of 0x40000 → sram_en stays 0; d_rsp_err=1 and data=0 after 3 cycles.
- **Reset mid-access**: handshake an i read, assert rst during WAIT → no i_rsp_valid; the next request completes normally.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_port_arbiter
//
// Two-requester front end for one single-port 64-bit L2 SRAM slice. The L1
// instruction side issues reads and the L1 data side issues reads or writes.
// A round-robin arbiter picks one request in IDLE. The access then runs
// IDLE -> ACCESS -> WAIT -> IDLE, and the winner gets a one-cycle registered
// response pulse three cycles after its handshake.
//
// Parameters
//   L2_SLICE_SIZE  slice size in bytes (power of two). Any address >= this
//                  is out of range: the SRAM is never enabled for it and the
//                  response comes back with err=1 and data=0.
//   CNT_W          width of the performance counters (they wrap).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_req_*                  instruction read request (valid/ready/addr)
//   i_rsp_*                  instruction response pulse, error, read data
//   d_req_*                  data request (valid/ready/we/addr/wdata/wstrb)
//   d_rsp_*                  data response pulse (also the write ack), error,
//                            read data (0 for writes)
//   sram_en/read/wstrb/addr/wdata, sram_rdata
//                            SRAM macro interface. Read data is valid in the
//                            cycle after the enable edge.
//   perf_i_grants, perf_d_grants, perf_conflicts
//                            grant counts per side, and the number of IDLE
//                            cycles in which both sides were requesting
// ---------------------------------------------------------------------------
module l2_port_arbiter #(
  parameter int unsigned L2_SLICE_SIZE = 262144,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             i_req_valid,
  output logic             i_req_ready,
  input  logic [31:0]      i_req_addr,
  output logic             i_rsp_valid,
  output logic             i_rsp_err,
  output logic [63:0]      i_rsp_data,

  input  logic             d_req_valid,
  output logic             d_req_ready,
  input  logic             d_req_we,
  input  logic [31:0]      d_req_addr,
  input  logic [63:0]      d_req_wdata,
  input  logic [7:0]       d_req_wstrb,
  output logic             d_rsp_valid,
  output logic             d_rsp_err,
  output logic [63:0]      d_rsp_data,

  output logic             sram_en,
  output logic             sram_read,
  output logic [7:0]       sram_wstrb,
  output logic [31:0]      sram_addr,
  output logic [63:0]      sram_wdata,
  input  logic [63:0]      sram_rdata,

  output logic [CNT_W-1:0] perf_i_grants,
  output logic [CNT_W-1:0] perf_d_grants,
  output logic [CNT_W-1:0] perf_conflicts
);

  localparam logic [31:0] SLICE_BYTES = 32'(L2_SLICE_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } state_t;

  state_t state;

  // Round-robin pointer: 1 means the data side wins the next conflict.
  logic prio_d;

  // Per-access latches held from the handshake until the response.
  logic lat_d;     // winner was the data side
  logic lat_we;    // access is a write
  logic lat_err;   // address out of range

  logic        grant_i;
  logic        grant_d;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic        sel_err;

  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst && state == IDLE) begin
      if (i_req_valid && (!d_req_valid || !prio_d)) begin
        grant_i = 1'b1;
      end else if (d_req_valid) begin
        grant_d = 1'b1;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  // Payload of whichever side wins this cycle. The instruction side only reads.
  assign sel_addr = grant_d ? d_req_addr : i_req_addr;
  assign sel_we   = grant_d & d_req_we;
  assign sel_err  = (sel_addr >= SLICE_BYTES);

  // NOTE: all state in this block uses non-blocking assignments, so every
  // register samples values from before the edge and no ordering race can
  // occur between the assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prio_d         <= 1'b0;
      lat_d          <= 1'b0;
      lat_we         <= 1'b0;
      lat_err        <= 1'b0;
      i_rsp_valid    <= 1'b0;
      i_rsp_err      <= 1'b0;
      i_rsp_data     <= '0;
      d_rsp_valid    <= 1'b0;
      d_rsp_err      <= 1'b0;
      d_rsp_data     <= '0;
      sram_en        <= 1'b0;
      sram_read      <= 1'b1;
      sram_wstrb     <= '0;
      sram_addr      <= '0;
      sram_wdata     <= '0;
      perf_i_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      // Response strobes are single-cycle pulses unless WAIT sets them again.
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;

      if (state == IDLE && i_req_valid && d_req_valid) begin
        perf_conflicts <= perf_conflicts + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            lat_d   <= grant_d;
            lat_we  <= sel_we;
            lat_err <= sel_err;
            // The side granted now loses the next tie.
            prio_d  <= grant_i;
            if (grant_i) perf_i_grants <= perf_i_grants + CNT_W'(1);
            if (grant_d) perf_d_grants <= perf_d_grants + CNT_W'(1);
            // The SRAM command is registered here so it is stable for the
            // whole ACCESS cycle and the macro samples it at the ACCESS exit.
            sram_en    <= !sel_err;
            sram_read  <= !sel_we;
            sram_wstrb <= sel_we ? d_req_wstrb : 8'h00;
            sram_addr  <= {sel_addr[31:3], 3'b000};
            sram_wdata <= grant_d ? d_req_wdata : 64'h0;
            state      <= ACCESS;
          end
        end

        ACCESS: begin
          // sram_addr and sram_wdata keep their values; only the command drops.
          sram_en    <= 1'b0;
          sram_read  <= 1'b1;
          sram_wstrb <= 8'h00;
          state      <= WAIT;
        end

        WAIT: begin
          // sram_rdata is valid in this cycle; capture it into the response.
          if (lat_d) begin
            d_rsp_valid <= 1'b1;
            d_rsp_err   <= lat_err;
            d_rsp_data  <= (!lat_we && !lat_err) ? sram_rdata : 64'h0;
          end else begin
            i_rsp_valid <= 1'b1;
            i_rsp_err   <= lat_err;
            i_rsp_data  <= !lat_err ? sram_rdata : 64'h0;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_port_arbiter
//
// Bench for l2_port_arbiter. A behavioural SRAM slice model answers the
// macro interface. Directed scenario tasks cover reset, write/read,
// partial strobes, conflicts, out-of-range and reset mid-access. A
// randomized two-requester run is compared against a transaction-level
// reference: a flat word array plus the arbitration rules, with the FSM
// modelled only as "busy for three cycles after a grant".
// ---------------------------------------------------------------------------
module tb_l2_port_arbiter;

  localparam int unsigned SLICE  = 262144;
  localparam int unsigned CW     = 32;
  localparam int unsigned WORDS  = SLICE / 8;
  localparam int          IDX_HI = $clog2(SLICE) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req_valid, i_req_ready;
  logic [31:0]   i_req_addr;
  logic          i_rsp_valid, i_rsp_err;
  logic [63:0]   i_rsp_data;
  logic          d_req_valid, d_req_ready, d_req_we;
  logic [31:0]   d_req_addr;
  logic [63:0]   d_req_wdata;
  logic [7:0]    d_req_wstrb;
  logic          d_rsp_valid, d_rsp_err;
  logic [63:0]   d_rsp_data;
  logic          sram_en, sram_read;
  logic [7:0]    sram_wstrb;
  logic [31:0]   sram_addr;
  logic [63:0]   sram_wdata, sram_rdata;
  logic [CW-1:0] perf_i_grants, perf_d_grants, perf_conflicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_port_arbiter #(.L2_SLICE_SIZE(SLICE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_err(i_rsp_err), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_err(d_rsp_err), .d_rsp_data(d_rsp_data),
    .sram_en(sram_en), .sram_read(sram_read), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
  );

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                              input logic [63:0] new_w,
                                              input logic [7:0]  strb);
    merge_bytes = old_w;
    for (int b = 0; b < 8; b++) if (strb[b]) merge_bytes[b*8 +: 8] = new_w[b*8 +: 8];
  endfunction

  // ---------------- SRAM slice model (environment) ----------------
  logic [63:0]       sram_mem [WORDS];
  bit                mem_init_done = 1'b0;
  logic [IDX_HI-3:0] sram_idx;
  int unsigned       sram_en_cycles = 0;

  assign sram_idx = sram_addr[IDX_HI:3];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < WORDS; k++) sram_mem[k] <= '0;
      mem_init_done <= 1'b1;
    end else if (sram_en === 1'b1 && sram_read === 1'b0) begin
      sram_mem[sram_idx] <= merge_bytes(sram_mem[sram_idx], sram_wdata, sram_wstrb);
    end
    // Garbage on Q whenever no read was issued, so stray captures show up.
    if (mem_init_done && sram_en === 1'b1 && sram_read === 1'b1) sram_rdata <= sram_mem[sram_idx];
    else sram_rdata <= {$urandom, $urandom};
  end

  always @(negedge clk) if (sram_en === 1'b1) sram_en_cycles <= sram_en_cycles + 1;

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [WORDS];

  function automatic void ref_access(input logic we, input logic [31:0] addr,
                                     input logic [63:0] wdata, input logic [7:0] wstrb,
                                     output logic err, output logic [63:0] data);
    int unsigned w;
    err  = (addr >= SLICE);
    data = 64'h0;
    if (err) return;
    w = addr / 8;
    if (we) ref_mem[w] = merge_bytes(ref_mem[w], wdata, wstrb);
    else    data = ref_mem[w];
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return 32'h0004_0000 + $urandom_range(0, 255) * 8 + $urandom_range(0, 7);
    if (r == 1) return $urandom | 32'h8000_0000;
    if (r == 2) return 32'h0003_FF00 + $urandom_range(0, 30) * 8 + $urandom_range(0, 7);
    return 32'h0000_1000 + $urandom_range(0, 31) * 8 + $urandom_range(0, 7);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One request on one side: waits for ready, then for the response.
  // lat = cycles from the handshake cycle to the response cycle (-1 on
  // timeout); stuck = response strobe still high the cycle after.
  task automatic txn(input bit side_d, input logic we, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wstrb,
                     output int lat, output logic err, output logic [63:0] data,
                     output logic stuck);
    int n;
    lat = -1; err = 1'b0; data = 64'h0; stuck = 1'b0;
    if (side_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr;
      d_req_wdata = wdata; d_req_wstrb = wstrb;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    #1;
    n = 0;
    while (!(side_d ? d_req_ready : i_req_ready) && n < 20) begin step(); n++; end
    if (!(side_d ? d_req_ready : i_req_ready)) begin
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      return;
    end
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) begin i_req_valid = 1'b0; d_req_valid = 1'b0; end
    end while (!(side_d ? d_rsp_valid : i_rsp_valid) && n < 20);
    if (side_d ? d_rsp_valid : i_rsp_valid) begin
      lat  = n;
      err  = side_d ? d_rsp_err : i_rsp_err;
      data = side_d ? d_rsp_data : i_rsp_data;
      step();
      stuck = side_d ? d_rsp_valid : i_rsp_valid;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h208;
    d_req_wdata = 64'h0; d_req_wstrb = 8'h00;
    step();
    step();
    checks++;
    if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got i=%b d=%b, expected 0 0", i_req_ready, d_req_ready);
    end
    checks++;
    if ({i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err} !== 4'b0000 ||
        i_rsp_data !== 64'h0 || d_rsp_data !== 64'h0) begin
      errors++; $display("FAIL reset_rsp: got v/e %b%b%b%b idata %h ddata %h, expected all 0",
                         i_rsp_valid, i_rsp_err, d_rsp_valid, d_rsp_err, i_rsp_data, d_rsp_data);
    end
    checks++;
    if (sram_en !== 1'b0 || sram_read !== 1'b1 || sram_wstrb !== 8'h00 ||
        sram_addr !== 32'h0 || sram_wdata !== 64'h0) begin
      errors++; $display("FAIL reset_sram: got en=%b rd=%b strb=%h addr=%h wdata=%h, expected 0 1 00 0 0",
                         sram_en, sram_read, sram_wstrb, sram_addr, sram_wdata);
    end
    checks++;
    if (perf_i_grants !== '0 || perf_d_grants !== '0 || perf_conflicts !== '0) begin
      errors++; $display("FAIL reset_perf: got %0d %0d %0d, expected 0 0 0",
                         perf_i_grants, perf_d_grants, perf_conflicts);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_first_grant: got i=%b d=%b, expected 1 0", i_req_ready, d_req_ready);
    end
    // Withdraw before the edge so no access starts.
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    int lat; logic err, stuck; logic [63:0] data; int unsigned en0;
    en0 = sram_en_cycles;
    txn(1'b1, 1'b1, 32'h100, 64'h1122334455667788, 8'hFF, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b0 || data !== 64'h0 || stuck !== 1'b0) begin
      errors++; $display("FAIL write_ack: got lat=%0d err=%b data=%h stuck=%b, expected 3 0 0 0",
                         lat, err, data, stuck);
    end
    checks++;
    if (sram_en_cycles - en0 != 1) begin
      errors++; $display("FAIL write_en_cycles: got %0d, expected 1", sram_en_cycles - en0);
    end
    txn(1'b1, 1'b0, 32'h104, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b0 || data !== 64'h1122334455667788 || stuck !== 1'b0) begin
      errors++; $display("FAIL d_read_back: got lat=%0d err=%b data=%h, expected 3 0 1122334455667788",
                         lat, err, data);
    end
    txn(1'b0, 1'b0, 32'h100, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b0 || data !== 64'h1122334455667788 || stuck !== 1'b0) begin
      errors++; $display("FAIL i_read_back: got lat=%0d err=%b data=%h, expected 3 0 1122334455667788",
                         lat, err, data);
    end
  endtask

  task automatic test_partial_strobe();
    int lat; logic err, stuck; logic [63:0] data; int unsigned en0;
    txn(1'b1, 1'b1, 32'h100, 64'hFFFFFFFFFFFFFFFF, 8'h0F, lat, err, data, stuck);
    txn(1'b1, 1'b0, 32'h100, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (lat != 3 || data !== 64'h11223344FFFFFFFF) begin
      errors++; $display("FAIL partial_strobe: got lat=%0d data=%h, expected 3 11223344ffffffff", lat, data);
    end
    en0 = sram_en_cycles;
    txn(1'b1, 1'b1, 32'h100, 64'hDEADBEEFDEADBEEF, 8'h00, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b0 || data !== 64'h0 || sram_en_cycles - en0 != 1) begin
      errors++; $display("FAIL zero_strobe_ack: got lat=%0d err=%b data=%h en=%0d, expected 3 0 0 1",
                         lat, err, data, sram_en_cycles - en0);
    end
    txn(1'b1, 1'b0, 32'h100, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (data !== 64'h11223344FFFFFFFF) begin
      errors++; $display("FAIL zero_strobe_unchanged: got %h, expected 11223344ffffffff", data);
    end
  endtask

  task automatic test_conflict();
    byte order [4];
    int  ng, cyc;
    apply_reset();
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h108;
    #1;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 40) begin
      if (i_req_ready && d_req_ready) begin order[ng] = "?"; ng++; end
      else if (i_req_ready) begin order[ng] = "I"; ng++; end
      else if (d_req_ready) begin order[ng] = "D"; ng++; end
      step();
      cyc++;
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    repeat (4) step();
    checks++;
    if (ng != 4) begin
      errors++; $display("FAIL conflict_grants_seen: got %0d, expected 4", ng);
    end
    for (int k = 0; k < ng; k++) begin
      checks++;
      if (order[k] != ((k % 2 == 0) ? "I" : "D")) begin
        errors++; $display("FAIL conflict_order[%0d]: got %c, expected %c", k, order[k],
                           (k % 2 == 0) ? "I" : "D");
      end
    end
    checks++;
    if (perf_conflicts !== CW'(4) || perf_i_grants !== CW'(2) || perf_d_grants !== CW'(2)) begin
      errors++; $display("FAIL conflict_perf: got conf=%0d i=%0d d=%0d, expected 4 2 2",
                         perf_conflicts, perf_i_grants, perf_d_grants);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic err, stuck; logic [63:0] data; int unsigned en0;
    en0 = sram_en_cycles;
    txn(1'b1, 1'b0, 32'h0004_0000, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b1 || data !== 64'h0 || sram_en_cycles != en0) begin
      errors++; $display("FAIL oor_read: got lat=%0d err=%b data=%h en=%0d, expected 3 1 0 0",
                         lat, err, data, sram_en_cycles - en0);
    end
    // Would alias onto word 0 if it reached the SRAM.
    txn(1'b1, 1'b1, 32'h0004_0000, 64'hA5A5A5A5A5A5A5A5, 8'hFF, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b1 || data !== 64'h0 || sram_en_cycles != en0) begin
      errors++; $display("FAIL oor_write: got lat=%0d err=%b data=%h en=%0d, expected 3 1 0 0",
                         lat, err, data, sram_en_cycles - en0);
    end
    txn(1'b0, 1'b0, 32'h0, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (err !== 1'b0 || data !== 64'h0) begin
      errors++; $display("FAIL oor_no_alias: got err=%b data=%h, expected 0 0", err, data);
    end
    txn(1'b1, 1'b1, 32'h0003_FFF8, 64'h0123456789ABCDEF, 8'hFF, lat, err, data, stuck);
    txn(1'b0, 1'b0, 32'h0003_FFFF, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b0 || data !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL last_word: got lat=%0d err=%b data=%h, expected 3 0 0123456789abcdef",
                         lat, err, data);
    end
    txn(1'b0, 1'b0, 32'hFFFF_FFF8, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b1 || data !== 64'h0) begin
      errors++; $display("FAIL i_oor: got lat=%0d err=%b data=%h, expected 3 1 0", lat, err, data);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic err, stuck; logic [63:0] data;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    #1;
    checks++;
    if (i_req_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: got %b, expected 1", i_req_ready);
    end
    step();               // ACCESS
    i_req_valid = 1'b0;
    step();               // WAIT
    rst = 1'b1;
    step();               // edge that would have produced the response
    checks++;
    if (i_rsp_valid !== 1'b0 || sram_en !== 1'b0 || perf_i_grants !== '0) begin
      errors++; $display("FAIL midrst_state: got rsp=%b en=%b igr=%0d, expected 0 0 0",
                         i_rsp_valid, sram_en, perf_i_grants);
    end
    rst = 1'b0;
    step();
    checks++;
    if (i_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_no_rsp: got %b, expected 0", i_rsp_valid);
    end
    txn(1'b0, 1'b0, 32'h100, 64'h0, 8'h00, lat, err, data, stuck);
    checks++;
    if (lat != 3 || err !== 1'b0 || data !== 64'h11223344FFFFFFFF || stuck !== 1'b0) begin
      errors++; $display("FAIL midrst_recover: got lat=%0d err=%b data=%h, expected 3 0 11223344ffffffff",
                         lat, err, data);
    end
  endtask

  task automatic test_random();
    bit          i_pend, d_pend, inflight, exp_side_d, last_d, gen, done;
    bit          exp_ri, exp_rd, exp_iv, exp_dv;
    logic [31:0] ia, da;
    logic        dwe, exp_err;
    logic [7:0]  dst;
    logic [63:0] dwd, exp_data;
    int          cyc, idle_at, due, n_i, n_d, n_conf;
    apply_reset();
    i_pend = 0; d_pend = 0; inflight = 0; exp_side_d = 0; done = 0;
    last_d = 1;  // after reset the instruction side wins the first tie
    ia = 0; da = 0; dwe = 0; dst = 0; dwd = 0; exp_err = 0; exp_data = 0;
    cyc = 0; idle_at = 0; due = 0; n_i = 0; n_d = 0; n_conf = 0;
    for (int k = 0; k < 3000; k++) begin
      gen = (k < 1500);
      exp_iv = inflight && due == cyc && !exp_side_d;
      exp_dv = inflight && due == cyc && exp_side_d;
      checks++;
      if (i_rsp_valid !== exp_iv || d_rsp_valid !== exp_dv) begin
        errors++; $display("FAIL rnd_rsp_valid cyc %0d: got i=%b d=%b, expected i=%b d=%b",
                           cyc, i_rsp_valid, d_rsp_valid, exp_iv, exp_dv);
      end
      if (exp_iv || exp_dv) begin
        checks++;
        if ((exp_dv ? d_rsp_err : i_rsp_err) !== exp_err ||
            (exp_dv ? d_rsp_data : i_rsp_data) !== exp_data) begin
          errors++; $display("FAIL rnd_rsp_payload cyc %0d side %s: got err=%b data=%h, expected err=%b data=%h",
                             cyc, exp_dv ? "d" : "i", exp_dv ? d_rsp_err : i_rsp_err,
                             exp_dv ? d_rsp_data : i_rsp_data, exp_err, exp_data);
        end
        inflight = 0;
      end
      if (!gen && !i_pend && !d_pend && !inflight) begin done = 1; break; end
      if (gen && !i_pend && $urandom_range(0, 1) == 1) begin i_pend = 1; ia = rand_addr(); end
      if (gen && !d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1; da = rand_addr(); dwe = 1'($urandom);
        dwd = {$urandom, $urandom}; dst = 8'($urandom);
      end
      i_req_valid = i_pend; i_req_addr = ia;
      d_req_valid = d_pend; d_req_addr = da; d_req_we = dwe;
      d_req_wdata = dwd; d_req_wstrb = dst;
      #1;
      exp_ri = 0; exp_rd = 0;
      if (cyc >= idle_at) begin
        if (i_pend && d_pend) begin
          n_conf++;
          exp_rd = !last_d;   // the side not granted last time wins
          exp_ri = last_d;
        end else begin
          exp_ri = i_pend;
          exp_rd = d_pend;
        end
      end
      checks++;
      if (i_req_ready !== exp_ri || d_req_ready !== exp_rd) begin
        errors++; $display("FAIL rnd_ready cyc %0d: got i=%b d=%b, expected i=%b d=%b",
                           cyc, i_req_ready, d_req_ready, exp_ri, exp_rd);
      end
      if (exp_ri || exp_rd) begin
        if (exp_rd) begin
          ref_access(dwe, da, dwd, dst, exp_err, exp_data);
          d_pend = 0; n_d++;
        end else begin
          ref_access(1'b0, ia, 64'h0, 8'h00, exp_err, exp_data);
          i_pend = 0; n_i++;
        end
        last_d = exp_rd; exp_side_d = exp_rd; inflight = 1;
        due = cyc + 3; idle_at = cyc + 3;
      end
      step();
      cyc++;
      if (!i_pend) i_req_valid = 1'b0;
      if (!d_pend) d_req_valid = 1'b0;
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL rnd_drain: random run did not drain within the cycle budget");
    end
    step();
    checks++;
    if (perf_i_grants !== CW'(n_i) || perf_d_grants !== CW'(n_d) || perf_conflicts !== CW'(n_conf)) begin
      errors++; $display("FAIL rnd_perf: got i=%0d d=%0d conf=%0d, expected i=%0d d=%0d conf=%0d",
                         perf_i_grants, perf_d_grants, perf_conflicts, n_i, n_d, n_conf);
    end
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) ref_mem[k] = '0;
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0;
    d_req_wdata = '0; d_req_wstrb = '0;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_conflict();
    test_out_of_range();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
